dff: RTL and testbench

Parameterizable edge-triggered D register with synchronous, active-low reset. It is the basic storage element used throughout the datapath wherever a signal must be held or delayed by whole clock cycles. Default parameters give a single-bit, single-stage D flip-flop. Larger parameter values give a multi-bit register or a shift-style delay line of identical stages.

---
 rtl/dff.sv | 65 ++++++
 tb/tb_dff.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff -- parameterizable D register / delay line with synchronous active-low
// reset.
//
// Purpose:
//   Basic storage element of the datapath. With default parameters it is a
//   single-bit, single-stage D flip-flop. With larger parameters it becomes a
//   WIDTH-bit register or a chain of STAGES identical stages that delays `d`
//   by STAGES rising edges of `clk`.
//
// Parameters:
//   WIDTH       - bit width of d and q (>= 1).
//   STAGES      - number of cascaded stages from d to q (legal range 1..16).
//   RESET_VALUE - value loaded into every stage while reset is low. It is
//                 truncated or zero-extended to WIDTH bits.
//
// Ports:
//   clk    in   1      rising-edge clock; all state changes happen here.
//   reset  in   1      synchronous reset, active low (0 = reset asserted).
//   d      in   WIDTH  data input, sampled on each rising edge.
//   q      out  WIDTH  content of the last stage.
// -----------------------------------------------------------------------------
module dff #(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Stage 0 is nearest to d, stage STAGES-1 drives q.
   logic [STAGES-1:0][WIDTH-1:0] stage_q;
   logic [STAGES-1:0][WIDTH-1:0] stage_d;

   // Next-state of the chain: d enters stage 0, every other stage takes the
   // value of its predecessor.
   // NOTE: every element of stage_d is assigned on every evaluation, so no
   // latch can be inferred from this block.
   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < int'(STAGES); i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Reset has priority over data and discards everything in flight, so
   // after release q shows RESET_VALUE until new data has reached the end.
   // NOTE: state is updated with non-blocking assignments so that each stage
   // samples its predecessor's value from before the edge, not after it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_q <= {STAGES{RESET_VALUE}};
      end else begin
         stage_q <= stage_d;
      end
   end

   // q is taken directly from a register: no combinational path from d or
   // reset to the output.
   assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff.sv
// -----------------------------------------------------------------------------
// tb_dff -- directed self-checking bench for dff.
//
// Two instances share one clock:
//   dut0 - default parameters (1 bit, 1 stage, reset value 0).
//   dut1 - WIDTH=8, STAGES=3, RESET_VALUE=8'hA5.
// Each instance has its own reset and data so the two scenarios stay
// independent. Inputs change on the falling edge; outputs are sampled 1 ns
// after the rising edge, or 1 ns after a falling-edge input change to show
// that nothing moves between rising edges.
// -----------------------------------------------------------------------------
module tb_dff;

   logic       clk;
   logic       rst0;
   logic       d0;
   logic       q0;
   logic       rst1;
   logic [7:0] d1;
   logic [7:0] q1;

   int n_checks = 0;
   int n_fail   = 0;

   dff dut0 (
      .clk   (clk),
      .reset (rst0),
      .d     (d0),
      .q     (q0)
   );

   dff #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5)
   ) dut1 (
      .clk   (clk),
      .reset (rst1),
      .d     (d1),
      .q     (q1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic after_rise();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst0 = 1'b0;
      d0   = 1'b0;
      rst1 = 1'b0;
      d1   = 8'h00;

      // ---------------- default instance ----------------
      // Reset hold: d toggles while reset is low, q stays 0 from the first edge.
      for (int i = 0; i < 3; i++) begin
         after_rise();
         check($sformatf("rst_hold_%0d", i), {7'b0, q0}, 8'h00);
         @(negedge clk);
         d0 = ~d0;
      end

      // Basic capture: 1, 0, 1.
      @(negedge clk);
      rst0 = 1'b1;
      d0   = 1'b1;
      after_rise();
      check("cap_1", {7'b0, q0}, 8'h01);
      @(negedge clk);
      d0 = 1'b0;
      #1;
      check("cap_stable_mid", {7'b0, q0}, 8'h01);
      after_rise();
      check("cap_0", {7'b0, q0}, 8'h00);
      @(negedge clk);
      d0 = 1'b1;
      after_rise();
      check("cap_1b", {7'b0, q0}, 8'h01);

      // Synchronous reset with d=1 at the same edge: q holds until the edge.
      @(negedge clk);
      rst0 = 1'b0;
      d0   = 1'b1;
      #1;
      check("rst_sync_hold", {7'b0, q0}, 8'h01);
      after_rise();
      check("rst_priority", {7'b0, q0}, 8'h00);

      // Release mid-cycle: no change until the edge, then d=1 is captured.
      @(negedge clk);
      rst0 = 1'b1;
      #1;
      check("release_sync_hold", {7'b0, q0}, 8'h00);
      after_rise();
      check("release_capture", {7'b0, q0}, 8'h01);

      // ---------------- 8-bit, 3-stage instance ----------------
      // rst1 has been low since time 0.
      check("p_rst_value", q1, 8'hA5);
      @(negedge clk);
      rst1 = 1'b1;
      d1   = 8'h01;
      after_rise();
      check("p_fill_e1", q1, 8'hA5);
      @(negedge clk);
      d1 = 8'h02;
      after_rise();
      check("p_fill_e2", q1, 8'hA5);
      @(negedge clk);
      d1 = 8'h03;
      after_rise();
      check("p_out_01", q1, 8'h01);
      @(negedge clk);
      d1 = 8'h04;
      after_rise();
      check("p_out_02", q1, 8'h02);
      @(negedge clk);
      d1 = 8'h05;
      after_rise();
      check("p_out_03", q1, 8'h03);

      // Reset mid-stream: in-flight data (04, 05, 06) is discarded.
      @(negedge clk);
      rst1 = 1'b0;
      d1   = 8'h06;
      #1;
      check("p_rst_sync_hold", q1, 8'h03);
      after_rise();
      check("p_rst_midstream", q1, 8'hA5);

      // Release again: reset value until 07 has crossed all three stages.
      @(negedge clk);
      rst1 = 1'b1;
      d1   = 8'h07;
      after_rise();
      check("p_rel_e1", q1, 8'hA5);
      @(negedge clk);
      d1 = 8'h08;
      after_rise();
      check("p_rel_e2", q1, 8'hA5);
      @(negedge clk);
      d1 = 8'h09;
      after_rise();
      check("p_rel_out_07", q1, 8'h07);
      @(negedge clk);
      after_rise();
      check("p_rel_out_08", q1, 8'h08);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
